// File: rtl/can_pkg.sv
// can_pkg: shared CAN definitions for the encoder and decoder.
// Holds the transmit field sequence enum, the field widths, the CRC-15
// generator polynomial, the bit-stuffing run limit and the captured frame
// record.
package can_pkg;

    localparam int ID_A_W      = 11;
    localparam int ID_B_W      = 18;
    localparam int DLC_W       = 4;
    localparam int DATA_W      = 64;
    localparam int CRC_W       = 15;
    localparam int STUFF_LIMIT = 5;

    localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

    // The declaration order is relied upon: SOF..CRC is the stuffed region
    // and SOF..DATA is the region covered by the CRC.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF,
        ST_ID_A,
        ST_SRR,
        ST_IDE,
        ST_ID_B,
        ST_RTR,
        ST_R1,
        ST_R0,
        ST_DLC,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK_SLOT,
        ST_ACK_DEL,
        ST_EOF
    } can_state_e;

    typedef struct packed {
        logic [ID_A_W-1:0] id_a;
        logic [ID_B_W-1:0] id_b;
        logic              ide;
        logic              rtr;
        logic [DLC_W-1:0]  dlc;
        logic [DATA_W-1:0] data;
    } can_frame_t;

endpackage

// File: rtl/can_encoder_if.sv
// can_encoder_if: transmit request, bit-timing strobe, bus bit and status
// signals of the CAN encoder.
//   master: controller side (drives the request and the strobe, reads status)
//   slave : encoder side
interface can_encoder_if;
    import can_pkg::*;

    logic              sample_point;
    logic              tx_start;
    logic [ID_A_W-1:0] field_id_a;
    logic [ID_B_W-1:0] field_id_b;
    logic              field_ide;
    logic              field_rtr;
    logic [DLC_W-1:0]  field_dlc;
    logic [DATA_W-1:0] field_data;
    logic              rx_bit;
    logic              tx_bit;
    logic              busy;
    logic              tx_done;
    logic              ack_error;

    modport master (
        output sample_point, tx_start, field_id_a, field_id_b, field_ide,
               field_rtr, field_dlc, field_data, rx_bit,
        input  tx_bit, busy, tx_done, ack_error
    );

    modport slave (
        input  sample_point, tx_start, field_id_a, field_id_b, field_ide,
               field_rtr, field_dlc, field_data, rx_bit,
        output tx_bit, busy, tx_done, ack_error
    );

endinterface

// File: rtl/can_crc15.sv
// can_crc15: serial CAN CRC-15 (x^15+x^14+x^10+x^8+x^7+x^4+x^3+1).
//   clock, reset : system clock, synchronous active-high reset
//   clear        : return the register to 0 (initial value)
//   enable       : shift in data_bit this cycle
//   data_bit     : next unstuffed frame bit
//   crc          : current remainder, MSB is the first bit transmitted
module can_crc15
    import can_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             data_bit,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q, crc_d;
    logic             feedback;

    always_comb begin
        crc_d    = crc_q;
        feedback = data_bit ^ crc_q[CRC_W-1];
        if (clear) begin
            crc_d = '0;
        end else if (enable) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) crc_q <= '0;
        else       crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/can_encoder.sv
// can_encoder: serializes one CAN 2.0A/2.0B data or remote frame onto
// tx_bit, one bit per sample_point strobe, with CRC-15 and bit stuffing.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : tx_start + field_* request, sample_point strobe, rx_bit
//                  readback (ACK slot), tx_bit output, busy / tx_done /
//                  ack_error status
// state_q names the field of the next bit to be driven and cnt_q the bit
// index inside that field.
module can_encoder
    import can_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 8,
    parameter int EOF_BITS       = 7
) (
    input  logic         clock,
    input  logic         reset,
    can_encoder_if.slave bus
);

    can_state_e       state_q, state_d, nxt_state;
    can_frame_t       frame_q, frame_d;
    logic [6:0]       cnt_q, cnt_d, field_len;
    logic [2:0]       stuff_cnt_q, stuff_cnt_d;
    logic             tx_bit_q, tx_bit_d;
    logic             busy_q, busy_d;
    logic             tx_done_q, tx_done_d;
    logic             ack_error_q, ack_error_d;
    logic [CRC_W-1:0] crc;
    logic             crc_clear, crc_en, field_bit, in_stuff, in_crc;
    logic [3:0]       nbytes;
    logic [6:0]       data_bits;

    can_crc15 u_crc (
        .clock    (clock),
        .reset    (reset),
        .clear    (crc_clear),
        .enable   (crc_en),
        .data_bit (field_bit),
        .crc      (crc)
    );

    // Payload length; the DLC field itself still carries the raw code.
    always_comb begin
        if (frame_q.rtr)                          nbytes = 4'd0;
        else if (frame_q.dlc > 4'(MAX_DATA_BYTES)) nbytes = 4'(MAX_DATA_BYTES);
        else                                      nbytes = frame_q.dlc;
        data_bits = {nbytes, 3'b000};
    end

    assign in_stuff = (state_q >= ST_SOF) && (state_q <= ST_CRC);
    assign in_crc   = (state_q >= ST_SOF) && (state_q <= ST_DATA);

    // Bit value, length and successor of the current field.
    always_comb begin
        field_bit = 1'b1;
        field_len = 7'd1;
        nxt_state = ST_IDLE;
        case (state_q)
            ST_SOF:      begin field_bit = 1'b0; nxt_state = ST_ID_A; end
            ST_ID_A: begin
                field_bit = frame_q.id_a[4'(ID_A_W-1) - cnt_q[3:0]];
                field_len = 7'(ID_A_W);
                nxt_state = frame_q.ide ? ST_SRR : ST_RTR;
            end
            ST_SRR:      nxt_state = ST_IDE;
            ST_IDE: begin
                field_bit = frame_q.ide;
                nxt_state = frame_q.ide ? ST_ID_B : ST_R0;
            end
            ST_ID_B: begin
                field_bit = frame_q.id_b[5'(ID_B_W-1) - cnt_q[4:0]];
                field_len = 7'(ID_B_W);
                nxt_state = ST_RTR;
            end
            ST_RTR: begin
                field_bit = frame_q.rtr;
                nxt_state = frame_q.ide ? ST_R1 : ST_IDE;
            end
            ST_R1:       begin field_bit = 1'b0; nxt_state = ST_R0; end
            ST_R0:       begin field_bit = 1'b0; nxt_state = ST_DLC; end
            ST_DLC: begin
                field_bit = frame_q.dlc[2'(DLC_W-1) - cnt_q[1:0]];
                field_len = 7'(DLC_W);
                nxt_state = (data_bits == 7'd0) ? ST_CRC : ST_DATA;
            end
            ST_DATA: begin
                field_bit = frame_q.data[6'(DATA_W-1) - cnt_q[5:0]];
                field_len = data_bits;
                nxt_state = ST_CRC;
            end
            ST_CRC: begin
                field_bit = crc[4'(CRC_W-1) - cnt_q[3:0]];
                field_len = 7'(CRC_W);
                nxt_state = ST_CRC_DEL;
            end
            ST_CRC_DEL:  nxt_state = ST_ACK_SLOT;
            ST_ACK_SLOT: nxt_state = ST_ACK_DEL;
            ST_ACK_DEL:  nxt_state = ST_EOF;
            default:     ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        cnt_d       = cnt_q;
        stuff_cnt_d = stuff_cnt_q;
        tx_bit_d    = tx_bit_q;
        busy_d      = busy_q;
        tx_done_d   = 1'b0;
        ack_error_d = ack_error_q;
        crc_clear   = 1'b0;
        crc_en      = 1'b0;

        if (state_q == ST_IDLE) begin
            // Acceptance never consumes a coincident strobe.
            if (bus.tx_start) begin
                frame_d.id_a = bus.field_id_a;
                frame_d.id_b = bus.field_id_b;
                frame_d.ide  = bus.field_ide;
                frame_d.rtr  = bus.field_rtr;
                frame_d.dlc  = bus.field_dlc;
                frame_d.data = bus.field_data;
                state_d      = ST_SOF;
                cnt_d        = '0;
                stuff_cnt_d  = '0;
                busy_d       = 1'b1;
                ack_error_d  = 1'b0;
                crc_clear    = 1'b1;
            end
        end else if (bus.sample_point) begin
            if (state_q == ST_EOF && cnt_q == 7'(EOF_BITS)) begin
                // This strobe ends the last EOF bit.
                state_d   = ST_IDLE;
                cnt_d     = '0;
                busy_d    = 1'b0;
                tx_done_d = 1'b1;
            end else if (stuff_cnt_q == 3'(STUFF_LIMIT)) begin
                // Also reached in CRC_DEL when the run ends on the last CRC bit.
                tx_bit_d    = ~tx_bit_q;
                stuff_cnt_d = 3'd1;
            end else begin
                tx_bit_d = field_bit;
                if (in_stuff)
                    stuff_cnt_d = (stuff_cnt_q != 3'd0 && field_bit == tx_bit_q) ?
                                  stuff_cnt_q + 3'd1 : 3'd1;
                else
                    stuff_cnt_d = 3'd0;
                crc_en = in_crc;
                // Driving ACK_DEL means the ACK slot has just ended.
                if (state_q == ST_ACK_DEL)
                    ack_error_d = ack_error_q | bus.rx_bit;
                if (state_q == ST_EOF) begin
                    cnt_d = cnt_q + 7'd1;
                end else if (cnt_q == field_len - 7'd1) begin
                    state_d = nxt_state;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            cnt_q       <= '0;
            stuff_cnt_q <= '0;
            tx_bit_q    <= 1'b1;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
            ack_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            cnt_q       <= cnt_d;
            stuff_cnt_q <= stuff_cnt_d;
            tx_bit_q    <= tx_bit_d;
            busy_q      <= busy_d;
            tx_done_q   <= tx_done_d;
            ack_error_q <= ack_error_d;
        end
    end

    assign bus.tx_bit    = tx_bit_q;
    assign bus.busy      = busy_q;
    assign bus.tx_done   = tx_done_q;
    assign bus.ack_error = ack_error_q;

endmodule

// File: tb/tb_can_encoder.sv
// tb_can_encoder: drives directed and random frames through can_encoder and
// compares the captured tx_bit stream against a frame model that builds the
// unstuffed bit list, derives the CRC by polynomial long division and then
// applies the stuffing rule to the resulting list.
module tb_can_encoder;
    import can_pkg::*;

    localparam int EOFB = 7;

    typedef logic q_t[$];

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    can_encoder_if bus();

    can_encoder #(.MAX_DATA_BYTES(8), .EOF_BITS(EOFB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;

    always @(negedge clock) if (bus.tx_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns #1 after the strobe edge.
    task automatic strobe();
        repeat (2) @(posedge clock);
        #1 bus.sample_point = 1'b1;
        @(posedge clock);
        #1 bus.sample_point = 1'b0;
    endtask

    task automatic build_exp(input can_frame_t f, output q_t s);
        q_t u, m;
        logic [15:0] gen = 16'hC599;
        int   n, run;
        logic prev, b;
        u = {};
        u.push_back(1'b0);
        for (int i = ID_A_W-1; i >= 0; i--) u.push_back(f.id_a[i]);
        if (f.ide) begin
            u.push_back(1'b1); u.push_back(1'b1);
            for (int i = ID_B_W-1; i >= 0; i--) u.push_back(f.id_b[i]);
            u.push_back(f.rtr); u.push_back(1'b0); u.push_back(1'b0);
        end else begin
            u.push_back(f.rtr); u.push_back(1'b0); u.push_back(1'b0);
        end
        for (int i = DLC_W-1; i >= 0; i--) u.push_back(f.dlc[i]);
        n = f.rtr ? 0 : ((f.dlc > 4'd8) ? 8 : int'(f.dlc));
        for (int i = 0; i < 8*n; i++) u.push_back(f.data[63-i]);
        // CRC = remainder of message * x^15 divided by the generator.
        m = u;
        for (int i = 0; i < 15; i++) m.push_back(1'b0);
        for (int i = 0; i < m.size() - 15; i++)
            if (m[i]) for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ gen[15-j];
        for (int i = m.size() - 15; i < m.size(); i++) u.push_back(m[i]);
        s = {};
        run = 0; prev = 1'b1;
        foreach (u[k]) begin
            b = u[k];
            s.push_back(b);
            run  = (run != 0 && b == prev) ? run + 1 : 1;
            prev = b;
            if (run == 5) begin
                s.push_back(~b);
                prev = ~b;
                run  = 1;
            end
        end
        for (int i = 0; i < 3 + EOFB; i++) s.push_back(1'b1);
    endtask

    // ign: while the frame runs, raise tx_start with different fields.
    task automatic run_frame(input string tag, input can_frame_t f, input logic nack,
                             input logic coinc, input logic ign, output int nbits);
        q_t   exp, rec;
        int   d0, errs;
        logic fin;
        build_exp(f, exp);
        bus.field_id_a = f.id_a; bus.field_id_b = f.id_b;
        bus.field_ide  = f.ide;  bus.field_rtr  = f.rtr;
        bus.field_dlc  = f.dlc;  bus.field_data = f.data;
        bus.rx_bit     = nack;
        bus.tx_start   = 1'b1;
        bus.sample_point = coinc;
        @(posedge clock);
        #1 bus.tx_start = 1'b0; bus.sample_point = 1'b0;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_ackclr"}, 64'(bus.ack_error), 64'd0);
        d0 = done_cnt; fin = 1'b0; rec = {};
        for (int k = 0; k < 400; k++) begin
            strobe();
            if (ign && k == 10) begin
                bus.tx_start = 1'b1;
                bus.field_id_a = ~f.id_a; bus.field_dlc = 4'd0; bus.field_rtr = ~f.rtr;
            end
            if (ign && k == 20) bus.tx_start = 1'b0;
            if (bus.busy === 1'b1) rec.push_back(bus.tx_bit);
            else begin
                fin = 1'b1;
                check({tag, "_done"}, 64'(bus.tx_done), 64'd1);
                check({tag, "_idle_bit"}, 64'(bus.tx_bit), 64'd1);
                break;
            end
        end
        bus.tx_start = 1'b0;
        check({tag, "_finished"}, 64'(fin), 64'd1);
        check({tag, "_len"}, 64'(rec.size()), 64'(exp.size()));
        errs = 0;
        foreach (rec[i]) if (i >= exp.size() || rec[i] !== exp[i]) errs++;
        check({tag, "_bits_wrong"}, 64'(errs), 64'd0);
        @(posedge clock); #1;
        check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_ack_err"}, 64'(bus.ack_error), 64'(nack));
        nbits = rec.size();
    endtask

    function automatic can_frame_t rnd_frame();
        can_frame_t f;
        f.id_a = 11'($urandom);
        f.id_b = 18'($urandom);
        f.ide  = 1'($urandom);
        f.rtr  = ($urandom_range(0, 3) == 0);
        f.dlc  = 4'($urandom);
        f.data = {$urandom, $urandom};
        return f;
    endfunction

    initial begin
        can_frame_t f;
        int nb, d0;
        bus.sample_point = 1'b0; bus.tx_start = 1'b0; bus.rx_bit = 1'b0;
        bus.field_id_a = '0; bus.field_id_b = '0; bus.field_ide = 1'b0;
        bus.field_rtr = 1'b0; bus.field_dlc = '0; bus.field_data = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx_bit", 64'(bus.tx_bit), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.tx_done), 64'd0);
        check("rst_ackerr", 64'(bus.ack_error), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // All-dominant standard frame: CRC 0, 50 bits SOF..EOF.
        f = '0;
        run_frame("zero", f, 1'b0, 1'b0, 1'b0, nb);
        check("zero_len50", 64'(nb), 64'd50);

        // id 0x123, two bytes A5 5A; acceptance coincides with a strobe.
        f = '0; f.id_a = 11'h123; f.dlc = 4'd2;
        f.data = {16'hA55A, 48'($urandom)};
        run_frame("std2", f, 1'b0, 1'b1, 1'b0, nb);

        // Extended remote frame, all-recessive identifiers.
        f = '0; f.ide = 1'b1; f.id_a = 11'h7FF; f.id_b = 18'h3FFFF;
        f.rtr = 1'b1; f.dlc = 4'd4; f.data = {$urandom, $urandom};
        run_frame("extrtr", f, 1'b0, 1'b0, 1'b0, nb);

        // DLC above capacity is clamped to 8 bytes; tx_start ignored while busy.
        f = rnd_frame(); f.rtr = 1'b0; f.dlc = 4'hC; f.ide = 1'b0;
        run_frame("dlcC", f, 1'b0, 1'b0, 1'b1, nb);

        // No acknowledge, then the next accept clears ack_error.
        f = rnd_frame();
        run_frame("nack", f, 1'b1, 1'b0, 1'b0, nb);
        f = rnd_frame(); f.ide = 1'b1;
        run_frame("after_nack", f, 1'b0, 1'b0, 1'b0, nb);

        // Reset in the middle of ID_A abandons the frame.
        f = rnd_frame();
        bus.field_id_a = f.id_a; bus.field_ide = f.ide; bus.field_dlc = f.dlc;
        bus.tx_start = 1'b1;
        @(posedge clock);
        #1 bus.tx_start = 1'b0;
        d0 = done_cnt;
        repeat (6) strobe();
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("midrst_tx_bit", 64'(bus.tx_bit), 64'd1);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.tx_done), 64'd0);
        repeat (4) strobe();
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        check("midrst_still_idle", 64'(bus.busy), 64'd0);
        f = rnd_frame();
        run_frame("post_rst", f, 1'b0, 1'b0, 1'b0, nb);

        for (int r = 0; r < 4; r++) begin
            f = rnd_frame();
            run_frame($sformatf("rnd%0d", r), f, 1'($urandom_range(0, 1)), 1'b0, 1'b0, nb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/can_encoder.md
# can_encoder

Serializes one CAN 2.0A/2.0B data or remote frame from parallel field inputs into a bit stream on `tx_bit`, with CRC-15 generation and bit stuffing. It is the transmit counterpart of `can_decoder`: it advances one bit per `sample_point` strobe and its output can be looped directly into the decoder's `rx_bit` for self-test. It sits between the controller's TX message register and the bus driver.

## Interface
- `MAX_DATA_BYTES`, default 8: data-field byte capacity; DLC values above this are clamped to it.
- `EOF_BITS`, default 7: number of recessive end-of-frame bits.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `sample_point`  in  1  one-cycle bit strobe; one bit time per strobe.
- `tx_start`  in  1  request to send the frame on the field inputs.
- `field_id_a`  in  11  base identifier, MSB first.
- `field_id_b`  in  18  extension identifier, MSB first; used only when `field_ide`=1.
- `field_ide`  in  1  1 = extended frame.
- `field_rtr`  in  1  1 = remote frame, with no data field.
- `field_dlc`  in  4  data length code.
- `field_data`  in  64  payload; byte 0 = [63:56], sent MSB first.
- `rx_bit`  in  1  bus readback, sampled in the ACK slot.
- `tx_bit`  out  1  serialized bit; 1 = recessive.
- `busy`  out  1  frame in progress.
- `tx_done`  out  1  one-cycle pulse after the last EOF bit.
- `ack_error`  out  1  set when the ACK slot read recessive; cleared on the next accepted `tx_start`.

## Operation
- Reset values: `tx_bit`=1, `busy`=0, `tx_done`=0, `ack_error`=0, state IDLE, CRC=0, stuff counter=0.
- In IDLE with `tx_start`=1, all field inputs are captured into a shadow register and `busy` is set in the same cycle. `tx_start` is ignored while `busy`=1.
- State sequence: IDLE → SOF(1) → ID_A(11) → standard frame: RTR → IDE(0) → R0; extended frame: SRR(1) → IDE(1) → ID_B(18) → RTR → R1 → R0. Both continue DLC(4) → DATA(8·n) → CRC(15) → CRC_DEL → ACK_SLOT → ACK_DEL → EOF(`EOF_BITS`) → IDLE.
- R1 and R0 are sent dominant (0). SRR, CRC_DEL, ACK_SLOT, ACK_DEL and EOF are sent recessive (1).
- Byte count n = 0 if `field_rtr`=1, else min(`field_dlc`, `MAX_DATA_BYTES`). The DLC field transmits the raw captured code.
- CRC: CAN CRC-15, polynomial 0x4599, initial value 0. It is updated with each unstuffed bit from SOF through the last DATA bit (or the DLC bit when n=0). CRC bits are sent MSB first.
- Stuffing applies from SOF through the last CRC bit. After 5 consecutive equal transmitted bits, one complement bit is inserted. The stuff bit is not fed to the CRC, and it starts a new run of length 1.
- If the 5th equal bit is the last CRC bit, the stuff bit is still sent before CRC_DEL. No stuffing is applied from CRC_DEL onward.
- In ACK_SLOT, `rx_bit` is sampled at the strobe that ends the slot; `ack_error` is set if it reads 1. The frame completes regardless of the ACK result.

## Timing
- All state, counter, CRC and `tx_bit` updates occur only on clock edges where `sample_point`=1. Between strobes, everything holds.
- The first strobe after acceptance drives SOF (`tx_bit`=0), visible the cycle after that strobe. Each later strobe drives the next bit.
- A loopback decoder samples each bit at the following strobe.
- `tx_done` pulses on the cycle following the strobe that ends the last EOF bit. `busy` falls in the same cycle, and `tx_bit` stays at 1.
- A new `tx_start` can be accepted on the cycle `busy` falls.
- A `reset` mid-frame returns all outputs to their reset values on the next edge. The partial frame is abandoned and no `tx_done` is issued.
- A `sample_point` in the same cycle as an accepting `tx_start` does not advance the frame. SOF goes out at the next strobe.

## Structure
- Package `can_pkg` holds the state enum, the CRC polynomial constant 15'h4599, the field widths (11, 18, 4, 64, 15), and the stuff limit of 5. It is shared with `can_decoder`.
- Sub-module `can_crc15` is a serial CRC-15 with inputs clock, reset, clear, enable and bit, and a 15-bit output. It is reused by the decoder.
- Bit counter: 7 bits, reloaded per field.

## Test plan
- All-dominant standard frame (id_a=0, rtr=0, dlc=0) → CRC=0. Output is 34 zero bits with 6 stuff bits inserted after zero-runs 5/10/15/20/25/30, giving 50 bits from SOF through EOF.
- Standard frame id_a=11'h123, dlc=2, data[63:48]=16'hA55A, looped into `can_decoder` → decoder fields match exactly. `tx_done` occurs once, and the destuffed bit count is 60.
- Extended frame (ide=1, id_a=11'h7FF, id_b=18'h3FFFF, rtr=1, dlc=4) → SRR=1 and IDE=1 are sent and no data bits follow. Stuff bits are inserted in the recessive runs, and the decoder recovers all fields.
- dlc=4'hC with rtr=0 → the DLC field is sent as 1100, exactly 64 data bits are sent, and the decoder `field_data` equals the input.
- `rx_bit` held at 1 during ACK_SLOT → `ack_error`=1 after the frame and `tx_done` still pulses. The next `tx_start` clears `ack_error`.
- `reset` asserted during ID_A, then a new `tx_start` → `tx_bit`=1 and `busy`=0 next cycle, with no `tx_done`. The following frame is bit-exact against a fresh-run golden model.
